// File: rtl/decode_queue.sv
// Fetch-to-dispatch decode queue: a small instruction FIFO whose head entry is
// decoded combinationally into a unit-tagged bundle for ROB / RS / LSB dispatch.
module decode_queue #(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 32
) (
    input  logic                       clk_in,
    input  logic                       rst_in,
    input  logic                       rdy_in,
    input  logic                       flush_in,
    input  logic                       inst_valid,
    input  logic [ADDR_W-1:0]          inst_addr,
    input  logic [31:0]                inst_data,
    output logic                       inst_ready,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [ADDR_W-1:0]          out_addr,
    output logic [1:0]                 out_unit,
    output logic [4:0]                 out_type,
    output logic [4:0]                 out_rd,
    output logic [4:0]                 out_rs1,
    output logic [4:0]                 out_rs2,
    output logic                       out_use_rd,
    output logic                       out_use_rs1,
    output logic                       out_use_rs2,
    output logic [31:0]                out_imm,
    output logic [ADDR_W-1:0]          out_next_pc,
    output logic [ADDR_W-1:0]          out_target,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic [6:0] {
        OP_LOAD    = 7'b0000011,
        OP_ARITH_I = 7'b0010011,
        OP_AUIPC   = 7'b0010111,
        OP_STORE   = 7'b0100011,
        OP_ARITH_R = 7'b0110011,
        OP_LUI     = 7'b0110111,
        OP_BRANCH  = 7'b1100011,
        OP_JALR    = 7'b1100111,
        OP_JAL     = 7'b1101111
    } opcode_e;

    typedef enum logic [1:0] {
        UNIT_ROB = 2'd0,
        UNIT_RS  = 2'd1,
        UNIT_LSB = 2'd2,
        UNIT_ILL = 2'd3
    } unit_e;

    logic [ADDR_W-1:0] addr_mem_q [DEPTH];
    logic [31:0]       data_mem_q [DEPTH];
    logic [PTR_W-1:0]  head_q, head_d;
    logic [PTR_W-1:0]  tail_q, tail_d;
    logic [CNT_W-1:0]  count_q, count_d;

    logic enq;
    logic deq;

    // Full queue refuses input even when the head leaves in the same cycle.
    assign inst_ready = rdy_in && !flush_in && (count_q != CNT_W'(DEPTH));
    assign out_valid  = (count_q != '0);
    assign enq        = inst_valid && inst_ready;
    assign deq        = out_valid && out_ready && rdy_in && !flush_in;
    assign count      = count_q;

    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (rst_in || (rdy_in && flush_in)) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            if (enq) tail_d = tail_q + PTR_W'(1);
            if (deq) head_d = head_q + PTR_W'(1);
            case ({enq, deq})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk_in) begin
        head_q  <= head_d;
        tail_q  <= tail_d;
        count_q <= count_d;
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                addr_mem_q[i] <= '0;
                data_mem_q[i] <= '0;
            end
        end else if (enq) begin
            addr_mem_q[tail_q] <= inst_addr;
            data_mem_q[tail_q] <= inst_data;
        end
    end

    logic [ADDR_W-1:0] head_addr;
    logic [31:0]       head_data;
    logic [6:0]        op;
    logic [2:0]        f3;
    logic [6:0]        f7;
    logic [31:0]       imm_i, imm_s, imm_b, imm_u, imm_j;

    assign head_addr = addr_mem_q[head_q];
    assign head_data = data_mem_q[head_q];
    assign op        = head_data[6:0];
    assign f3        = head_data[14:12];
    assign f7        = head_data[31:25];

    assign imm_i = {{20{head_data[31]}}, head_data[31:20]};
    assign imm_s = {{20{head_data[31]}}, head_data[31:25], head_data[11:7]};
    assign imm_b = {{19{head_data[31]}}, head_data[31], head_data[7],
                    head_data[30:25], head_data[11:8], 1'b0};
    assign imm_u = {head_data[31:12], 12'b0};
    assign imm_j = {{11{head_data[31]}}, head_data[31], head_data[19:12],
                    head_data[20], head_data[30:21], 1'b0};

    unit_e             unit;
    logic [4:0]        typ;
    logic              use_rd, use_rs1, use_rs2;
    logic [31:0]       imm;
    logic [ADDR_W-1:0] target;

    always_comb begin
        unit    = UNIT_ILL;
        typ     = '0;
        use_rd  = 1'b0;
        use_rs1 = 1'b0;
        use_rs2 = 1'b0;
        imm     = '0;
        target  = '0;
        case (op)
            OP_ARITH_R: begin
                unit    = UNIT_RS;
                typ     = {1'b0, f7[5], f3};
                use_rd  = 1'b1;
                use_rs1 = 1'b1;
                use_rs2 = 1'b1;
            end
            OP_ARITH_I: begin
                // Only SRAI carries the alternate bit; ADDI's imm[10] is data.
                unit    = UNIT_RS;
                typ     = {1'b0, (f3 == 3'b101) && f7[5], f3};
                use_rd  = 1'b1;
                use_rs1 = 1'b1;
                imm     = imm_i;
            end
            OP_BRANCH: begin
                unit    = UNIT_RS;
                typ     = {2'b10, f3};
                use_rs1 = 1'b1;
                use_rs2 = 1'b1;
                imm     = imm_b;
                target  = head_addr + ADDR_W'($signed(imm_b));
            end
            OP_LOAD: begin
                unit    = UNIT_LSB;
                typ     = {2'b00, f3};
                use_rd  = 1'b1;
                use_rs1 = 1'b1;
                imm     = imm_i;
            end
            OP_STORE: begin
                unit    = UNIT_LSB;
                typ     = {2'b01, f3};
                use_rs1 = 1'b1;
                use_rs2 = 1'b1;
                imm     = imm_s;
            end
            OP_LUI: begin
                unit    = UNIT_ROB;
                use_rd  = 1'b1;
                imm     = imm_u;
            end
            OP_AUIPC: begin
                unit    = UNIT_ROB;
                use_rd  = 1'b1;
                imm     = imm_u;
                target  = head_addr + ADDR_W'($signed(imm_u));
            end
            OP_JAL: begin
                unit    = UNIT_ROB;
                use_rd  = 1'b1;
                imm     = imm_j;
                target  = head_addr + ADDR_W'($signed(imm_j));
            end
            OP_JALR: begin
                unit    = UNIT_ROB;
                use_rd  = 1'b1;
                use_rs1 = 1'b1;
                imm     = imm_i;
            end
            default: begin
                unit    = UNIT_ILL;
            end
        endcase
    end

    assign out_addr    = head_addr;
    assign out_unit    = unit;
    assign out_type    = typ;
    assign out_use_rd  = use_rd;
    assign out_use_rs1 = use_rs1;
    assign out_use_rs2 = use_rs2;
    assign out_rd      = use_rd  ? head_data[11:7]  : '0;
    assign out_rs1     = use_rs1 ? head_data[19:15] : '0;
    assign out_rs2     = use_rs2 ? head_data[24:20] : '0;
    assign out_imm     = imm;
    assign out_next_pc = head_addr + ADDR_W'(4);
    assign out_target  = target;

endmodule

// File: tb/tb_decode_queue.sv
// Scoreboard bench for decode_queue: directed instruction vectors with
// hand-decoded expected bundles, checked by an independent dispatch monitor.
module tb_decode_queue;

    logic        clk_in = 1'b0;
    logic        rst_in, rdy_in, flush_in, inst_valid, out_ready;
    logic [31:0] inst_addr, inst_data;
    logic        inst_ready, out_valid;
    logic [31:0] out_addr, out_imm, out_next_pc, out_target;
    logic [1:0]  out_unit;
    logic [4:0]  out_type, out_rd, out_rs1, out_rs2;
    logic        out_use_rd, out_use_rs1, out_use_rs2;
    logic [2:0]  count;

    always #5 clk_in = ~clk_in;

    decode_queue #(.DEPTH(4), .ADDR_W(32)) dut (
        .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .flush_in(flush_in),
        .inst_valid(inst_valid), .inst_addr(inst_addr), .inst_data(inst_data),
        .inst_ready(inst_ready), .out_valid(out_valid), .out_ready(out_ready),
        .out_addr(out_addr), .out_unit(out_unit), .out_type(out_type),
        .out_rd(out_rd), .out_rs1(out_rs1), .out_rs2(out_rs2),
        .out_use_rd(out_use_rd), .out_use_rs1(out_use_rs1), .out_use_rs2(out_use_rs2),
        .out_imm(out_imm), .out_next_pc(out_next_pc), .out_target(out_target),
        .count(count)
    );

    typedef struct {
        logic [31:0] addr;
        logic [31:0] inst;
        logic [1:0]  unit;
        logic [4:0]  typ, rd, rs1, rs2;
        logic        urd, urs1, urs2;
        logic [31:0] imm, npc, tgt;
    } vec_t;

    vec_t vt [13];
    vec_t sb [$];
    vec_t mon_v;
    int   checks = 0;
    int   errors = 0;

    function automatic vec_t mk(input logic [31:0] addr, inst, input logic [1:0] unit,
                                input logic [4:0] typ, rd, rs1, rs2,
                                input logic urd, urs1, urs2,
                                input logic [31:0] imm, npc, tgt);
        vec_t v;
        v.addr = addr; v.inst = inst; v.unit = unit; v.typ = typ;
        v.rd = rd; v.rs1 = rs1; v.rs2 = rs2;
        v.urd = urd; v.urs1 = urs1; v.urs2 = urs2;
        v.imm = imm; v.npc = npc; v.tgt = tgt;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", name, got, exp);
        end
    endtask

    // Dispatch monitor: every handshake pops the oldest expected bundle.
    always @(negedge clk_in) begin
        if (!rst_in && out_valid && out_ready && rdy_in && !flush_in) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL unexpected_dispatch got addr %h inst-unit %0d expected none",
                         out_addr, out_unit);
            end else begin
                mon_v = sb.pop_front();
                if ({out_addr, out_unit, out_type, out_rd, out_rs1, out_rs2,
                     out_use_rd, out_use_rs1, out_use_rs2, out_imm, out_next_pc, out_target} !==
                    {mon_v.addr, mon_v.unit, mon_v.typ, mon_v.rd, mon_v.rs1, mon_v.rs2,
                     mon_v.urd, mon_v.urs1, mon_v.urs2, mon_v.imm, mon_v.npc, mon_v.tgt}) begin
                    errors++;
                    $display("FAIL dispatch_%h got addr=%h unit=%0d type=%b rd=%0d rs1=%0d rs2=%0d use=%b%b%b imm=%h npc=%h tgt=%h expected addr=%h unit=%0d type=%b rd=%0d rs1=%0d rs2=%0d use=%b%b%b imm=%h npc=%h tgt=%h",
                             mon_v.addr, out_addr, out_unit, out_type, out_rd, out_rs1, out_rs2,
                             out_use_rd, out_use_rs1, out_use_rs2, out_imm, out_next_pc, out_target,
                             mon_v.addr, mon_v.unit, mon_v.typ, mon_v.rd, mon_v.rs1, mon_v.rs2,
                             mon_v.urd, mon_v.urs1, mon_v.urs2, mon_v.imm, mon_v.npc, mon_v.tgt);
                end
            end
        end
    end

    task automatic offer(input int idx, input bit acc);
        inst_valid = 1'b1;
        inst_addr  = vt[idx].addr;
        inst_data  = vt[idx].inst;
        @(negedge clk_in);
        chk($sformatf("inst_ready_v%0d", idx), {31'b0, inst_ready}, {31'b0, acc});
        if (acc) sb.push_back(vt[idx]);
        @(posedge clk_in); #1;
        inst_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got timeout expected finish");
        $fatal(1);
    end

    initial begin
        //          addr          inst          u     type      rd  rs1 rs2 urd urs1 urs2 imm           npc           tgt
        vt[0]  = mk(32'h100,      32'hFFF08293, 2'd1, 5'b00000, 5,  1,  0,  1, 1, 0, 32'hFFFFFFFF, 32'h104,      32'h0);
        vt[1]  = mk(32'h104,      32'h002081B3, 2'd1, 5'b00000, 3,  1,  2,  1, 1, 1, 32'h0,        32'h108,      32'h0);
        vt[2]  = mk(32'h108,      32'h402081B3, 2'd1, 5'b01000, 3,  1,  2,  1, 1, 1, 32'h0,        32'h10C,      32'h0);
        vt[3]  = mk(32'h10C,      32'h00812203, 2'd2, 5'b00010, 4,  2,  0,  1, 1, 0, 32'h8,        32'h110,      32'h0);
        vt[4]  = mk(32'h110,      32'hFE512E23, 2'd2, 5'b01010, 0,  2,  5,  0, 1, 1, 32'hFFFFFFFC, 32'h114,      32'h0);
        vt[5]  = mk(32'h114,      32'h123453B7, 2'd0, 5'b00000, 7,  0,  0,  1, 0, 0, 32'h12345000, 32'h118,      32'h0);
        vt[6]  = mk(32'h118,      32'h40315093, 2'd1, 5'b01101, 1,  2,  0,  1, 1, 0, 32'h403,      32'h11C,      32'h0);
        vt[7]  = mk(32'h11C,      32'h00315093, 2'd1, 5'b00101, 1,  2,  0,  1, 1, 0, 32'h3,        32'h120,      32'h0);
        vt[8]  = mk(32'h0,        32'hFE000CE3, 2'd1, 5'b10000, 0,  0,  0,  0, 1, 1, 32'hFFFFFFF8, 32'h4,        32'hFFFFFFF8);
        vt[9]  = mk(32'h200,      32'h00001417, 2'd0, 5'b00000, 8,  0,  0,  1, 0, 0, 32'h1000,     32'h204,      32'h1200);
        vt[10] = mk(32'h300,      32'h010000EF, 2'd0, 5'b00000, 1,  0,  0,  1, 0, 0, 32'h10,       32'h304,      32'h310);
        vt[11] = mk(32'h304,      32'h00008067, 2'd0, 5'b00000, 0,  1,  0,  1, 1, 0, 32'h0,        32'h308,      32'h0);
        vt[12] = mk(32'h400,      32'h0000007F, 2'd3, 5'b00000, 0,  0,  0,  0, 0, 0, 32'h0,        32'h404,      32'h0);

        rst_in = 1'b1; rdy_in = 1'b1; flush_in = 1'b0; inst_valid = 1'b0; out_ready = 1'b0;
        inst_addr = '0; inst_data = '0;
        repeat (2) @(posedge clk_in);
        #1 rst_in = 1'b0;
        @(negedge clk_in);
        chk("reset_count", {29'b0, count}, 32'd0);
        chk("reset_out_valid", {31'b0, out_valid}, 32'd0);
        chk("reset_inst_ready", {31'b0, inst_ready}, 32'd1);
        @(posedge clk_in); #1;

        // single ADDI: visible the cycle after enqueue
        offer(0, 1'b1);
        out_ready = 1'b1;
        @(negedge clk_in);
        chk("latency_out_valid", {31'b0, out_valid}, 32'd1);
        chk("latency_count", {29'b0, count}, 32'd1);
        @(posedge clk_in); #1;
        out_ready = 1'b0;
        @(negedge clk_in);
        chk("after_pop_count", {29'b0, count}, 32'd0);
        @(posedge clk_in); #1;

        // fill to DEPTH, refuse a fifth, drain in order
        for (int i = 1; i <= 4; i++) offer(i, 1'b1);
        offer(5, 1'b0);
        @(negedge clk_in);
        chk("full_count", {29'b0, count}, 32'd4);
        chk("full_inst_ready", {31'b0, inst_ready}, 32'd0);
        @(posedge clk_in); #1;
        out_ready = 1'b1;
        repeat (4) @(posedge clk_in);
        #1;
        @(negedge clk_in);
        chk("drained_count", {29'b0, count}, 32'd0);
        chk("drained_out_valid", {31'b0, out_valid}, 32'd0);
        @(posedge clk_in); #1;

        // streaming with concurrent enqueue/dequeue
        offer(6, 1'b1);
        offer(7, 1'b1);
        offer(8, 1'b1);
        @(negedge clk_in);
        chk("stream_count", {29'b0, count}, 32'd1);
        @(posedge clk_in); #1;
        for (int i = 9; i <= 11; i++) offer(i, 1'b1);
        @(posedge clk_in); #1;
        @(negedge clk_in);
        chk("stream_end_count", {29'b0, count}, 32'd0);
        @(posedge clk_in); #1;

        // flush with three buffered and one offered
        out_ready = 1'b0;
        for (int i = 1; i <= 3; i++) offer(i, 1'b1);
        inst_valid = 1'b1; inst_addr = vt[4].addr; inst_data = vt[4].inst;
        flush_in = 1'b1;
        @(negedge clk_in);
        chk("flush_inst_ready", {31'b0, inst_ready}, 32'd0);
        chk("preflush_count", {29'b0, count}, 32'd3);
        sb.delete();
        @(posedge clk_in); #1;
        flush_in = 1'b0; inst_valid = 1'b0;
        @(negedge clk_in);
        chk("flush_count", {29'b0, count}, 32'd0);
        chk("flush_out_valid", {31'b0, out_valid}, 32'd0);
        @(posedge clk_in); #1;
        out_ready = 1'b1;
        repeat (3) @(posedge clk_in);
        #1;

        // rdy_in low freezes everything
        out_ready = 1'b0;
        offer(5, 1'b1);
        offer(6, 1'b1);
        rdy_in = 1'b0; out_ready = 1'b1;
        inst_valid = 1'b1; inst_addr = vt[7].addr; inst_data = vt[7].inst;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk_in);
            chk("stall_inst_ready", {31'b0, inst_ready}, 32'd0);
            chk("stall_count", {29'b0, count}, 32'd2);
            chk("stall_head_addr", out_addr, vt[5].addr);
            chk("stall_head_type", {27'b0, out_type}, {27'b0, vt[5].typ});
            @(posedge clk_in); #1;
        end
        rdy_in = 1'b1; inst_valid = 1'b0;
        repeat (2) @(posedge clk_in);
        #1;
        offer(12, 1'b1);
        @(posedge clk_in); #1;
        @(negedge clk_in);
        chk("post_stall_count", {29'b0, count}, 32'd0);
        chk("sb_drained", sb.size(), 32'd0);
        @(posedge clk_in); #1;

        // reset mid-operation empties the queue
        out_ready = 1'b0;
        offer(1, 1'b1);
        offer(2, 1'b1);
        rst_in = 1'b1;
        sb.delete();
        @(posedge clk_in); #1;
        rst_in = 1'b0;
        @(negedge clk_in);
        chk("midreset_count", {29'b0, count}, 32'd0);
        chk("midreset_out_valid", {31'b0, out_valid}, 32'd0);
        @(posedge clk_in); #1;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
